// File: rtl/uart_tx_if.sv
// uart_tx_if: byte valid/ready handshake between a producer and the UART transmitter
interface uart_tx_if;
    logic [7:0] data_i;
    logic       valid_i;
    logic       ready_o;
    modport master (output data_i, valid_i, input ready_o);
    modport slave (input data_i, valid_i, output ready_o);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8-bit serial transmitter with optional parity and 1 or 2 stop bits
module uart_tx #(
    parameter int   CLK_FREQ   = 25000000,
    parameter int   BAUD_RATE  = 115200,
    parameter logic IF_PARITY  = 1'b0,
    parameter logic PARITY_ODD = 1'b0,
    parameter int   STOP_BITS  = 1,
    parameter int   FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    uart_tx_if.slave                    bus,
    output logic                        tx_o,
    output logic                        busy_o,
    output logic [$clog2(FIFO_DEPTH):0] level_o
);
    localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
    localparam int BW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [2:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity;
    logic          push, pop, bit_end, frame_end;

    assign bus.ready_o = !rst_i && (level_o < (AW+1)'(FIFO_DEPTH));
    assign push = bus.valid_i && bus.ready_o;
    assign bit_end = baud_cnt == BAUD_LAST;
    assign frame_end = state == STOP && bit_end && bit_cnt == STOP_LAST;
    assign pop = |level_o && (state == IDLE || frame_end);

    // Byte storage; entries are only read while level_o says they hold data, so no reset
    always_ff @(posedge clk_i)
        if (push) mem[wr_ptr] <= bus.data_i;

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the level unchanged
    always_ff @(posedge clk_i)
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_o <= '0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(push);
            rd_ptr  <= rd_ptr + AW'(pop);
            level_o <= level_o + (AW+1)'(push) - (AW+1)'(pop);
        end

    // Frame sequencer; the last stop cycle pops straight into START so queued frames abut
    always_ff @(posedge clk_i)
        if (rst_i) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            parity   <= 1'b0;
        end else begin
            baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
            if (pop) begin
                shift  <= mem[rd_ptr];
                parity <= ^mem[rd_ptr] ^ PARITY_ODD;
            end else if (state == DATA && bit_end) begin
                shift <= shift >> 1;
            end
            case (state)
                IDLE:    if (pop) state <= START;
                START:   if (bit_end) state <= DATA;
                DATA:    if (bit_end) begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == 3'd7) state <= IF_PARITY ? PARITY : STOP;
                end
                PARITY:  if (bit_end) state <= STOP;
                STOP:    if (bit_end) begin
                    bit_cnt <= frame_end ? '0 : bit_cnt + 1'b1;
                    if (frame_end) state <= pop ? START : IDLE;
                end
                default: state <= IDLE;
            endcase
        end

    // Line level and busy flag follow the state one cycle later, keeping tx_o a pure register
    always_ff @(posedge clk_i)
        if (rst_i) begin
            tx_o   <= 1'b1;
            busy_o <= 1'b0;
        end else begin
            tx_o   <= state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? parity : 1'b1;
            busy_o <= state != IDLE || |level_o;
        end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized bench checking uart_tx line waveforms against a frame-level model
module tb_uart_tx;
    localparam int DIV = 25000000 / 115200;
    localparam int LIMIT = 20000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic [3:0] valid = 4'h0;
    logic [3:0] tx, busy, rdy;
    logic [3:0][2:0] lvl;
    int cyc = 0, total = 0, passed = 0;
    int fall_cyc = -1, push_cyc = 0;
    logic [7:0] exp_q[$];

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_if b0(), b1(), b2(), b3();
    assign b0.data_i = data;
    assign b1.data_i = data;
    assign b2.data_i = data;
    assign b3.data_i = data;
    assign b0.valid_i = valid[0];
    assign b1.valid_i = valid[1];
    assign b2.valid_i = valid[2];
    assign b3.valid_i = valid[3];
    assign rdy = {b3.ready_o, b2.ready_o, b1.ready_o, b0.ready_o};

    uart_tx u0 (.clk_i(clk), .rst_i(rst), .bus(b0), .tx_o(tx[0]), .busy_o(busy[0]), .level_o(lvl[0]));
    uart_tx #(.IF_PARITY(1'b1)) u1 (.clk_i(clk), .rst_i(rst), .bus(b1), .tx_o(tx[1]), .busy_o(busy[1]), .level_o(lvl[1]));
    uart_tx #(.IF_PARITY(1'b1), .PARITY_ODD(1'b1)) u2 (.clk_i(clk), .rst_i(rst), .bus(b2), .tx_o(tx[2]), .busy_o(busy[2]), .level_o(lvl[2]));
    uart_tx #(.STOP_BITS(2)) u3 (.clk_i(clk), .rst_i(rst), .bus(b3), .tx_o(tx[3]), .busy_o(busy[3]), .level_o(lvl[3]));

    // sel 0: defaults, 1: even parity, 2: odd parity, 3: two stop bits
    function automatic int n_bits(input int sel);
        return 9 + ((sel == 1 || sel == 2) ? 1 : 0) + (sel == 3 ? 2 : 1);
    endfunction

    function automatic logic line_bit(input int sel, input logic [7:0] b, input int k);
        int ones = $countones(b);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && (sel == 1 || sel == 2)) return 1'(ones % 2) ^ (sel == 2);
        return 1'b1;
    endfunction

    task automatic push(input int sel, input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        data = b;
        valid[sel] = 1'b1;
        while (!rdy[sel] && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 valid[sel] = 1'b0;
        push_cyc = cyc;
        total++;
        if (n >= LIMIT) $display("FAIL push%0d: ready=%b after %0d cycles, need 1", sel, rdy[sel], n);
        else passed++;
    endtask

    task automatic check_frames(input int sel, input string name);
        int n = exp_q.size(), len = n_bits(sel) * DIV, waited = 0, bad, first_bad;
        logic got, want, bad_got, bad_want;
        do begin
            @(negedge clk);
            waited++;
        end while (tx[sel] !== 1'b0 && waited < LIMIT);
        total++;
        if (tx[sel] !== 1'b0) begin
            $display("FAIL %s start: tx=%b after %0d cycles, need 0", name, tx[sel], waited);
            return;
        end
        passed++;
        fall_cyc = cyc;
        for (int f = 0; f < n; f++) begin
            bad = 0;
            first_bad = -1;
            bad_got = 1'b0;
            bad_want = 1'b0;
            for (int c = 0; c < len; c++) begin
                if (f != 0 || c != 0) @(negedge clk);
                want = line_bit(sel, exp_q[f], c / DIV);
                got = tx[sel];
                if (got !== want) begin
                    if (bad == 0) begin
                        first_bad = c;
                        bad_got = got;
                        bad_want = want;
                    end
                    bad++;
                end
            end
            total++;
            if (bad != 0)
                $display("FAIL %s frame %0d (0x%02h): %0d wrong cycles, first at %0d tx=%b need %b",
                         name, f, exp_q[f], bad, first_bad, bad_got, bad_want);
            else passed++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 4;
        if (tx !== 4'hF) $display("FAIL reset tx: %b, need 1111", tx); else passed++;
        if (busy !== 4'h0) $display("FAIL reset busy: %b, need 0000", busy); else passed++;
        if (lvl !== '0) $display("FAIL reset level: %h, need 0", lvl); else passed++;
        if (rdy !== 4'h0) $display("FAIL reset ready while rst: %b, need 0000", rdy); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (rdy !== 4'hF) $display("FAIL ready after reset: %b, need 1111", rdy); else passed++;
    endtask

    task automatic test_single;
        int lows = 0;
        repeat (5) @(negedge clk);
        exp_q = {8'h41};
        fork
            push(0, 8'h41);
            check_frames(0, "single");
        join
        total += 5;
        if (fall_cyc - push_cyc !== 2) $display("FAIL single latency: %0d, need 2", fall_cyc - push_cyc); else passed++;
        if (busy[0] !== 1'b1) $display("FAIL single busy in last stop cycle: %b, need 1", busy[0]); else passed++;
        @(negedge clk);
        if (busy[0] !== 1'b0) $display("FAIL single busy after 2170: %b, need 0", busy[0]); else passed++;
        if (lvl[0] !== 3'd0) $display("FAIL single level: %0d, need 0", lvl[0]); else passed++;
        repeat (300) begin
            @(negedge clk);
            if (tx[0] !== 1'b1) lows++;
        end
        if (lows !== 0) $display("FAIL single idle line: %0d low cycles, need 0", lows); else passed++;
    endtask

    task automatic test_parity(input int sel);
        repeat (5) @(negedge clk);
        exp_q = {8'h41, 8'h07};
        fork
            begin
                push(sel, 8'h41);
                push(sel, 8'h07);
            end
            check_frames(sel, sel == 1 ? "even" : "odd");
        join
        @(negedge clk);
        total++;
        if (busy[sel] !== 1'b0) $display("FAIL parity%0d busy at end: %b, need 0", sel, busy[sel]); else passed++;
    endtask

    task automatic test_burst;
        int acc[6];
        int idx = 0, n = 0, lv_mid = -1, rd_mid = -1;
        logic hs;
        repeat (5) @(negedge clk);
        exp_q = {8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        fork
            begin
                data = 8'h00;
                valid[0] = 1'b1;
                while (idx < 6 && n < LIMIT) begin
                    hs = rdy[0];
                    if (idx == 5 && cyc == acc[0] + 1000) begin
                        lv_mid = int'(lvl[0]);
                        rd_mid = int'(rdy[0]);
                    end
                    @(posedge clk);
                    #1;
                    if (hs) begin
                        acc[idx] = cyc;
                        idx++;
                        data = 8'(idx);
                    end
                    @(negedge clk);
                    n++;
                end
                valid[0] = 1'b0;
            end
            check_frames(0, "burst");
        join
        total += 5;
        if (idx !== 6) $display("FAIL burst accepted: %0d, need 6", idx); else passed++;
        if (acc[4] - acc[0] !== 4) $display("FAIL burst first five span: %0d, need 4", acc[4] - acc[0]); else passed++;
        if (lv_mid !== 4 || rd_mid !== 0) $display("FAIL burst full: level=%0d ready=%0d, need 4 and 0", lv_mid, rd_mid); else passed++;
        if (acc[5] - acc[0] !== 2172) $display("FAIL burst sixth accept: %0d, need 2172", acc[5] - acc[0]); else passed++;
        @(negedge clk);
        if (busy[0] !== 1'b0 || lvl[0] !== 3'd0) $display("FAIL burst end: busy=%b level=%0d, need 0 0", busy[0], lvl[0]); else passed++;
    endtask

    task automatic test_push_pop;
        logic [7:0] q[4];
        int n = 0, lv_before = -1, lv_after = -1;
        repeat (5) @(negedge clk);
        foreach (q[i]) q[i] = 8'($urandom);
        exp_q = {q[0], q[1], q[2], q[3]};
        fall_cyc = -1;
        fork
            begin
                push(0, q[0]);
                push(0, q[1]);
                push(0, q[2]);
                while (fall_cyc < 0 && n < LIMIT) begin
                    @(negedge clk);
                    n++;
                end
                while (cyc < fall_cyc + 2168 && n < LIMIT) begin
                    @(negedge clk);
                    n++;
                end
                lv_before = int'(lvl[0]);
                data = q[3];
                valid[0] = 1'b1;
                @(posedge clk);
                #1 valid[0] = 1'b0;
                @(negedge clk);
                lv_after = int'(lvl[0]);
            end
            check_frames(0, "pushpop");
        join
        total += 2;
        if (lv_before !== 2) $display("FAIL pushpop level before: %0d, need 2", lv_before); else passed++;
        if (lv_after !== 2) $display("FAIL pushpop level after: %0d, need 2", lv_after); else passed++;
    endtask

    task automatic test_mid_reset;
        int n = 0, t0, lows = 0, busies = 0;
        logic [7:0] b;
        repeat (5) @(negedge clk);
        push(0, 8'($urandom));
        push(0, 8'($urandom));
        push(0, 8'($urandom));
        while (tx[0] !== 1'b0 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        t0 = cyc;
        while (cyc < t0 + 4 * DIV + 100) @(negedge clk);
        total++;
        if (lvl[0] !== 3'd2) $display("FAIL midreset queued: %0d, need 2", lvl[0]); else passed++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total += 5;
        if (tx[0] !== 1'b1) $display("FAIL midreset tx: %b, need 1", tx[0]); else passed++;
        if (lvl[0] !== 3'd0) $display("FAIL midreset level: %0d, need 0", lvl[0]); else passed++;
        if (busy[0] !== 1'b0) $display("FAIL midreset busy: %b, need 0", busy[0]); else passed++;
        repeat (3000) begin
            @(negedge clk);
            if (tx[0] !== 1'b1) lows++;
            if (busy[0] !== 1'b0) busies++;
        end
        if (lows !== 0) $display("FAIL midreset line after: %0d low cycles, need 0", lows); else passed++;
        if (busies !== 0) $display("FAIL midreset busy after: %0d cycles, need 0", busies); else passed++;
        b = 8'($urandom);
        exp_q = {b};
        fork
            push(0, b);
            check_frames(0, "afterreset");
        join
    endtask

    task automatic test_stop2;
        repeat (5) @(negedge clk);
        exp_q = {8'hFF, 8'h00};
        fork
            begin
                push(3, 8'hFF);
                push(3, 8'h00);
            end
            check_frames(3, "stop2");
        join
    endtask

    task automatic test_random;
        logic [7:0] q[4];
        repeat (5) @(negedge clk);
        foreach (q[i]) q[i] = 8'($urandom);
        exp_q = {q[0], q[1], q[2], q[3]};
        fork
            foreach (q[i]) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                push(0, q[i]);
            end
            check_frames(0, "random");
        join
    endtask

    initial begin
        test_reset;
        test_single;
        test_parity(1);
        test_parity(2);
        test_burst;
        test_push_pop;
        test_mid_reset;
        test_stop2;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #(40 * 150000);
        $display("FAIL watchdog: simulation exceeded 150000 cycles, %0d/%0d passed", passed, total);
        $fatal(1);
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter counterpart to the existing UART receiver; carries status and readback bytes from the VGA controller to the host over the same 115200 baud 8-N-1 link.
- Accepts bytes on a valid/ready handshake into a small internal FIFO.
- Serialises each byte LSB-first with start bit, optional parity bit and stop bit(s) on tx_o.
- Runs in the 25 MHz pixel clock domain.

Parameters:
- CLK_FREQ, 25000000, input clock frequency in Hz.
- BAUD_RATE, 115200, line rate in baud; BAUD_DIV = CLK_FREQ/BAUD_RATE with integer truncation, giving 217 at defaults.
- IF_PARITY, 1'b0, 1 = insert parity bit after data bits.
- PARITY_ODD, 1'b0, 0 = even parity, 1 = odd parity; ignored when IF_PARITY=0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
- FIFO_DEPTH, 4, byte FIFO entries; must be a power of two, minimum 2.

Ports:
- clk_i  input  1  system clock (25 MHz).
- rst_i  input  1  synchronous reset, active-high.
- data_i  input  8  byte to transmit.
- valid_i  input  1  data_i valid.
- ready_o  output  1  FIFO can accept; a push occurs on any edge where valid_i && ready_o.
- tx_o  output  1  serial line; idles high.
- busy_o  output  1  high while a frame is on the line or the FIFO is non-empty.
- level_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst_i high at an edge):
  - After that edge: tx_o=1, ready_o=1, busy_o=0, level_o=0, state=IDLE, baud and bit counters cleared, FIFO flushed.
  - ready_o is forced 0 while rst_i is high.
  - A mid-frame reset aborts the frame; tx_o returns high on the following cycle, with no partial stop bit.
- FIFO:
  - ready_o = (level_o < FIFO_DEPTH), combinational from the registered count.
  - A push and a pop on the same edge leave level_o unchanged.
  - No push is possible when full. A pop never occurs when empty.
  - Data order is strictly FIFO.
- Registers: tx_o is driven from a register, so there is no combinational path from inputs to tx_o.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx_o=1. On an edge with level_o != 0: pop the head into the shift register, compute parity, go to START.
  - A byte pushed into an empty FIFO at edge N is popped at edge N+1. tx_o falls after edge N+2.
  - START: tx_o=0 for BAUD_DIV cycles, then DATA.
  - DATA: 8 bits, each BAUD_DIV cycles, shift register bit 0 first, then shift right. After bit 7 go to PARITY if IF_PARITY, else STOP.
  - PARITY: tx_o = ^data XOR PARITY_ODD for BAUD_DIV cycles.
  - STOP: tx_o=1 for STOP_BITS*BAUD_DIV cycles.
  - On the last STOP cycle: if the FIFO is non-empty, pop and go directly to START, so frames are back-to-back with no idle gap. Otherwise go to IDLE.
- Baud counter:
  - Counts 0..BAUD_DIV-1 and reloads on each bit boundary.
  - Width is $clog2(BAUD_DIV).
  - Bit counter is 3 bits.
- Frame length: (1+8+IF_PARITY+STOP_BITS)*BAUD_DIV clocks. At defaults this is 2170.
- busy_o = (state != IDLE) || (level_o != 0), registered with the state. It deasserts on the cycle tx_o completes the last stop bit with an empty FIFO.
- valid_i without ready_o: data_i is not captured. The source must hold data_i until the handshake completes.

Test Plan:
- Reset, then push 0x41 in a single cycle, defaults:
  - tx_o goes low 2 cycles after the push edge and stays low for 217 clocks.
  - Data bits follow, 217 clocks each: 1,0,0,0,0,0,1,0.
  - Stop bit is high for 217 clocks.
  - busy_o drops 2170 clocks after the first low; tx_o stays 1 afterwards.
- IF_PARITY=1: push 0x41, then 0x07.
  - Even (PARITY_ODD=0): parity bits are 0, then 1.
  - Odd (PARITY_ODD=1): parity bits are 1, then 0.
  - Each frame is 2387 clocks.
- Burst of 6 bytes 0x00–0x05 with valid_i held high:
  - 5 are accepted: 1 is popped immediately, then 4 fill the FIFO.
  - ready_o is low while level_o=4.
  - The 6th is accepted on the cycle the 2nd byte is popped, at the end of frame 1.
  - All 6 frames are contiguous, with no high gap beyond the stop bit.
- Push and pop on the same edge (level_o=2, push during end-of-stop pop): level_o stays 2, and byte order is preserved on the line.
- Assert rst_i during data bit 3 of a frame with 2 bytes queued:
  - tx_o=1 next cycle.
  - level_o=0, busy_o=0.
  - No further frames are sent.
  - A new push after reset transmits correctly.
- STOP_BITS=2: push 0xFF, 0x00 → stop region high for 434 clocks between the frames, and the 0x00 start bit follows immediately.
